scrambler_frame_ctrl: RTL
=========================

# scrambler_frame_ctrl

Frame sequencer and flow-control wrapper for the 16-bit symbol scrambler. It accepts a valid/ready sample stream, groups the samples into fixed-length frames, and gates the scrambler's enable one cycle per accepted sample. It also inserts idle gap cycles between frames and re-times the scrambler's unstallable registered output into a 4-entry output buffer that tolerates backpressure. It sits between the sample source and the FFT input stage.

## Interface

Parameters:
- `FRAME_LEN`, default 64: samples per frame; legal range 2..65535.
- `GAP`, default 2: idle cycles (scrambler disabled) between frames; 0 is legal.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `run` in 1: level enable. Frames start only while high.
- `s_valid` in 1: input sample valid.
- `s_ready` out 1: input sample accepted when `s_valid & s_ready`.
- `s_data` in 16: input sample.
- `scr_en` out 1: scrambler enable (combinational, equal to `s_valid & s_ready`).
- `scr_inp` out 16: scrambler input (combinational, equal to `s_data`).
- `scr_outp` in 16: scrambler registered output.
- `m_valid` out 1: output buffer non-empty.
- `m_ready` in 1: downstream accepts the head entry.
- `m_data` out 16: scrambled sample at the buffer head.
- `m_first` out 1: head entry is sample 0 of its frame.
- `m_last` out 1: head entry is sample `FRAME_LEN-1` of its frame.
- `frame_cnt` out 16: number of frames whose last sample has been accepted at the input; wraps modulo 2^16.
- `busy` out 1: high when the state is not IDLE, or `pend` is set, or the buffer is non-empty.

## Operation

- FSM states: IDLE, RUN, GAP.
  - IDLE → RUN when `run` = 1.
  - RUN → GAP when the `FRAME_LEN`-th sample of a frame is accepted and `GAP` > 0.
  - RUN → RUN with `smp_cnt` cleared on that same last accept when `GAP` = 0 and `run` = 1.
  - RUN → IDLE on that last accept when `GAP` = 0 and `run` = 0.
  - GAP → RUN after `GAP` cycles if `run` = 1; otherwise GAP → IDLE.
- `run` falling mid-frame never truncates a frame. The current frame completes, and the transition to IDLE happens at the frame boundary (after the gap when `GAP` > 0).
- `smp_cnt` (16 bits) counts accepted samples in the current frame, 0..`FRAME_LEN-1`. `gap_cnt` counts gap cycles.
- `pend` is a 1-bit register set to `scr_en`. It marks that `scr_outp` holds a fresh result this cycle. It carries the first/last tags (`pend_first` = `smp_cnt`==0, `pend_last` = `smp_cnt`==`FRAME_LEN-1`, both captured at accept).
- Output buffer: 4 entries × 18 bits `{first, last, data}`, circular, with 2-bit read/write pointers and a 3-bit occupancy `cnt_o`.
  - Push when `pend` = 1, writing `{pend_first, pend_last, scr_outp}`.
  - Pop when `m_valid & m_ready`.
  - A simultaneous push and pop leaves `cnt_o` unchanged.
- `s_ready` = (state == RUN) & ((`cnt_o` + `pend`) < 4). There is no credit for a same-cycle pop. This bound guarantees a push can never hit a full buffer (no overflow path exists).
- `scr_en` is low in IDLE and GAP, so the scrambler holds its LFSR state and its output reads 0. The controller never samples `scr_outp` when `pend` = 0.
- `frame_cnt` increments on the last-sample accept.
- Reset mid-operation: buffer contents and the in-flight `pend` sample are discarded, and `frame_cnt` clears. The scrambler LFSR has no reset and continues from its current state; sequence realignment is a system-level concern.

## Timing

- Reset values: state IDLE; `s_ready`=0, `scr_en`=0, `m_valid`=0, `m_first`=0, `m_last`=0, `m_data`=0, `frame_cnt`=0, `busy`=0; `pend`=0, `cnt_o`=0, both pointers 0, `smp_cnt`=0, `gap_cnt`=0.
- `s_ready` rises in the first cycle with state RUN, which is 1 cycle after `run` is sampled high in IDLE.
- Latency: a sample accepted in cycle t appears in `scr_outp` in t+1, is pushed into the buffer at the end of t+1, and is visible with `m_valid` in t+2. Input-to-output latency is 2 cycles.
- Throughput: with `m_ready` held at 1, sustained rate is 1 sample per cycle within a frame (steady state `cnt_o`=1, `pend`=1).
- Frame period at full rate is `FRAME_LEN` + `GAP` cycles.
- With `m_ready` = 0, at most 4 samples are accepted after the buffer was empty. `s_ready` drops when `cnt_o` + `pend` reaches 4.
- `m_data`, `m_first` and `m_last` are stable while `m_valid & !m_ready`.

## Test plan

- **Reset and idle:** with `rst` high for 3 cycles and `run`=0, all outputs read 0 and `s_ready`=0 for 10 cycles.
- **Frame sequencing:** `FRAME_LEN`=4, `GAP`=2, `run`=1, `s_valid`=1, `m_ready`=1.
  - Inputs are 0x0001..0x0008.
  - `s_ready` pattern is 1111 00 1111.
  - `m_first` is set on outputs 0 and 4; `m_last` on outputs 3 and 7.
  - `frame_cnt` reads 2.
  - Each output equals a reference scrambler model fed the same enables.
- **Latency:** a single sample accepted at cycle t gives `m_valid` exactly at t+2.
- **Backpressure:** `m_ready`=0 from the start gives exactly 4 accepts, then `s_ready`=0. Releasing `m_ready` drains the 4 entries in order, then input accepts resume.
- **`run` drop mid-frame:** drop `run` after sample 1 of 4. Samples 2 and 3 are still accepted, then GAP, then IDLE; `frame_cnt` increments by 1 and `busy` falls once drained.
- **Reset mid-frame:** assert `rst` with `cnt_o`=2 and `pend`=1. The next cycle shows `m_valid`=0 and `frame_cnt`=0, and no stale output appears afterward.

Source files
------------

// File: rtl/scrambler_frame_ctrl.sv
// Frame sequencer for the 16-bit symbol scrambler: gates the scrambler one cycle per accepted
// sample, inserts idle gaps between frames and re-times the scrambler output into a 4-deep buffer.
module scrambler_frame_ctrl #(
  parameter int FRAME_LEN = 64,
  parameter int GAP       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        scr_en,
  output logic [15:0] scr_inp,
  input  logic [15:0] scr_outp,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_first,
  output logic        m_last,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP} state_t;

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);
  localparam logic [15:0] GAP_M1   = (GAP > 0) ? 16'(GAP - 1) : 16'd0;

  state_t      r_state;
  logic [15:0] r_smp_cnt;
  logic [15:0] r_gap_cnt;
  logic [15:0] r_frame_cnt;
  logic        r_pend;
  logic        r_pend_first;
  logic        r_pend_last;
  logic [17:0] r_buf [4];
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_cnt_o;

  logic [3:0]  w_occ;
  logic        w_acc;
  logic        w_pop;
  logic        w_last;
  logic [17:0] w_head;

  // Occupancy counts the in-flight scrambler result, so a push can never find the buffer full.
  assign w_occ     = {1'b0, r_cnt_o} + {3'b000, r_pend};
  assign s_ready   = (r_state == ST_RUN) && (w_occ < 4'd4);
  assign w_acc     = s_valid & s_ready;
  assign scr_en    = w_acc;
  assign scr_inp   = s_data;
  assign w_last    = (r_smp_cnt == LAST_IDX);

  assign m_valid   = (r_cnt_o != 3'd0);
  assign w_pop     = m_valid & m_ready;
  assign w_head    = m_valid ? r_buf[r_rptr] : 18'd0;
  assign m_first   = w_head[17];
  assign m_last    = w_head[16];
  assign m_data    = w_head[15:0];
  assign frame_cnt = r_frame_cnt;
  assign busy      = (r_state != ST_IDLE) | r_pend | m_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_smp_cnt    <= 16'd0;
      r_gap_cnt    <= 16'd0;
      r_frame_cnt  <= 16'd0;
      r_pend       <= 1'b0;
      r_pend_first <= 1'b0;
      r_pend_last  <= 1'b0;
      r_wptr       <= 2'd0;
      r_rptr       <= 2'd0;
      r_cnt_o      <= 3'd0;
    end else begin
      r_pend       <= w_acc;
      r_pend_first <= (r_smp_cnt == 16'd0);
      r_pend_last  <= w_last;

      // scr_outp is only meaningful the cycle after an accept
      if (r_pend) begin
        r_buf[r_wptr] <= {r_pend_first, r_pend_last, scr_outp};
        r_wptr        <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
      end
      case ({r_pend, w_pop})
        2'b10:   r_cnt_o <= r_cnt_o + 3'd1;
        2'b01:   r_cnt_o <= r_cnt_o - 3'd1;
        default: r_cnt_o <= r_cnt_o;
      endcase

      case (r_state)
        ST_IDLE: begin
          if (run) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_acc) begin
            if (w_last) begin
              r_smp_cnt   <= 16'd0;
              r_frame_cnt <= r_frame_cnt + 16'd1;
              if (GAP > 0) begin
                r_state   <= ST_GAP;
                r_gap_cnt <= GAP_M1;
              end else if (!run) begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_smp_cnt <= r_smp_cnt + 16'd1;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == 16'd0) begin
            r_state <= run ? ST_RUN : ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
